// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at dispatch, captures CDB results,
// retires in program order and raises a one-cycle flush on a mispredicted branch.
module reorder_buffer #(
   parameter int TAG_W  = 5,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              disp_valid,
   input  logic              disp_rd_en,
   input  logic [4:0]        disp_rd_addr,
   output logic              disp_ready,
   output logic [TAG_W-1:0]  disp_tag,
   output logic              Wen_rst,
   output logic [4:0]        Waddr_rst,
   output logic [TAG_W-1:0]  Wdata_rst,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   input  logic              cdb_mispredict,
   input  logic [TAG_W-1:0]  rs_qtag,
   input  logic [TAG_W-1:0]  rt_qtag,
   output logic              rs_qready,
   output logic              rt_qready,
   output logic [DATA_W-1:0] rs_qdata,
   output logic [DATA_W-1:0] rt_qdata,
   output logic [TAG_W-1:0]  RB_tag_rst,
   output logic              RB_valid_rst,
   output logic              commit_wen,
   output logic [4:0]        commit_addr,
   output logic [DATA_W-1:0] commit_data,
   output logic              flush
);
   localparam int DEPTH = 2 ** TAG_W;

   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  done;
   logic [DEPTH-1:0]  misp;
   logic [DEPTH-1:0]  rd_en;
   logic [4:0]        rd_addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   logic [TAG_W-1:0]  head;
   logic [TAG_W-1:0]  tail;
   logic [TAG_W:0]    count;

   logic do_disp;
   logic do_cpl;
   logic do_commit;
   logic rs_hit;
   logic rt_hit;

   // count never exceeds DEPTH, so its top bit alone marks a full buffer.
   assign disp_ready = ~count[TAG_W] & ~flush;
   assign disp_tag   = tail;
   assign do_disp    = disp_valid & disp_ready;
   assign Wen_rst    = do_disp & disp_rd_en;
   assign Waddr_rst  = disp_rd_addr;
   assign Wdata_rst  = tail;

   assign do_cpl    = ~flush & cdb_valid & busy[cdb_tag] & ~done[cdb_tag];
   assign do_commit = ~flush & (count != '0) & busy[head] & done[head];

   // Operand query forwards a same-cycle CDB broadcast to a pending entry.
   assign rs_hit    = cdb_valid & (cdb_tag == rs_qtag) & busy[rs_qtag];
   assign rt_hit    = cdb_valid & (cdb_tag == rt_qtag) & busy[rt_qtag];
   assign rs_qready = (busy[rs_qtag] & done[rs_qtag]) | rs_hit;
   assign rt_qready = (busy[rt_qtag] & done[rt_qtag]) | rt_hit;
   assign rs_qdata  = rs_hit ? cdb_data : data_mem[rs_qtag];
   assign rt_qdata  = rt_hit ? cdb_data : data_mem[rt_qtag];

   always_ff @(posedge clock) begin
      if (reset) begin
         busy         <= '0;
         done         <= '0;
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         RB_tag_rst   <= '0;
         RB_valid_rst <= 1'b0;
         commit_wen   <= 1'b0;
         commit_addr  <= '0;
         commit_data  <= '0;
         flush        <= 1'b0;
      end else begin
         RB_valid_rst <= 1'b0;
         commit_wen   <= 1'b0;
         flush        <= 1'b0;
         if (flush) begin
            busy  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (do_disp) begin
               busy[tail]        <= 1'b1;
               done[tail]        <= 1'b0;
               rd_en[tail]       <= disp_rd_en;
               rd_addr_mem[tail] <= disp_rd_addr;
               tail              <= tail + 1'b1;
            end
            if (do_cpl) begin
               done[cdb_tag]     <= 1'b1;
               data_mem[cdb_tag] <= cdb_data;
               misp[cdb_tag]     <= cdb_mispredict;
            end
            if (do_commit) begin
               busy[head]   <= 1'b0;
               head         <= head + 1'b1;
               RB_tag_rst   <= head;
               RB_valid_rst <= rd_en[head];
               commit_wen   <= rd_en[head];
               commit_addr  <= rd_addr_mem[head];
               commit_data  <= data_mem[head];
               flush        <= misp[head];
            end
            if (do_disp && !do_commit)
               count <= count + 1'b1;
            else if (!do_disp && do_commit)
               count <= count - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random traffic
// against a program-order queue model of the buffer.
module tb_reorder_buffer;
   localparam int TAG_W  = 5;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 32;

   logic              clock = 1'b0;
   logic              reset;
   logic              disp_valid, disp_rd_en;
   logic [4:0]        disp_rd_addr;
   logic              disp_ready;
   logic [TAG_W-1:0]  disp_tag;
   logic              Wen_rst;
   logic [4:0]        Waddr_rst;
   logic [TAG_W-1:0]  Wdata_rst;
   logic              cdb_valid, cdb_mispredict;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;
   logic [TAG_W-1:0]  rs_qtag, rt_qtag;
   logic              rs_qready, rt_qready;
   logic [DATA_W-1:0] rs_qdata, rt_qdata;
   logic [TAG_W-1:0]  RB_tag_rst;
   logic              RB_valid_rst, commit_wen, flush;
   logic [4:0]        commit_addr;
   logic [DATA_W-1:0] commit_data;

   reorder_buffer #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .clock(clock), .reset(reset),
      .disp_valid(disp_valid), .disp_rd_en(disp_rd_en), .disp_rd_addr(disp_rd_addr),
      .disp_ready(disp_ready), .disp_tag(disp_tag),
      .Wen_rst(Wen_rst), .Waddr_rst(Waddr_rst), .Wdata_rst(Wdata_rst),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .cdb_mispredict(cdb_mispredict),
      .rs_qtag(rs_qtag), .rt_qtag(rt_qtag),
      .rs_qready(rs_qready), .rt_qready(rt_qready),
      .rs_qdata(rs_qdata), .rt_qdata(rt_qdata),
      .RB_tag_rst(RB_tag_rst), .RB_valid_rst(RB_valid_rst),
      .commit_wen(commit_wen), .commit_addr(commit_addr), .commit_data(commit_data),
      .flush(flush)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: tags in program order plus per-tag attributes.
   logic [TAG_W-1:0]  rob_q[$];
   logic [TAG_W-1:0]  next_tag;
   logic              m_done [DEPTH];
   logic              m_misp [DEPTH];
   logic              m_rden [DEPTH];
   logic [4:0]        m_addr [DEPTH];
   logic [DATA_W-1:0] m_data [DEPTH];
   logic [TAG_W-1:0]  e_rb_tag;
   logic              e_rb_valid, e_cwen, e_flush;
   logic [4:0]        e_caddr;
   logic [DATA_W-1:0] e_cdata;

   logic [TAG_W-1:0]  log_tag[$];
   logic [DATA_W-1:0] log_data[$];
   logic [TAG_W-1:0]  flush_log[$];

   function automatic bit in_rob(logic [TAG_W-1:0] t);
      foreach (rob_q[i]) if (rob_q[i] == t) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_step();
      bit do_c, do_d, do_p;
      logic [TAG_W-1:0] h;
      e_rb_valid = 1'b0;
      e_cwen     = 1'b0;
      if (reset) begin
         rob_q.delete();
         next_tag = '0; e_rb_tag = '0; e_caddr = '0; e_cdata = '0; e_flush = 1'b0;
         return;
      end
      if (e_flush) begin
         rob_q.delete();
         next_tag = '0;
         e_flush  = 1'b0;
         return;
      end
      do_c = rob_q.size() != 0 && m_done[rob_q[0]];
      do_d = disp_valid && rob_q.size() < DEPTH;
      do_p = cdb_valid && in_rob(cdb_tag) && !m_done[cdb_tag];
      e_flush = 1'b0;
      if (do_c) begin
         h          = rob_q.pop_front();
         e_rb_tag   = h;
         e_rb_valid = m_rden[h];
         e_cwen     = m_rden[h];
         e_caddr    = m_addr[h];
         e_cdata    = m_data[h];
         e_flush    = m_misp[h];
      end
      if (do_p) begin
         m_done[cdb_tag] = 1'b1;
         m_data[cdb_tag] = cdb_data;
         m_misp[cdb_tag] = cdb_mispredict;
      end
      if (do_d) begin
         rob_q.push_back(next_tag);
         m_done[next_tag] = 1'b0;
         m_rden[next_tag] = disp_rd_en;
         m_addr[next_tag] = disp_rd_addr;
         next_tag = next_tag + 1'b1;
      end
   endtask

   task automatic check_query(string tag, logic [TAG_W-1:0] q, logic rdy, logic [DATA_W-1:0] dat);
      bit hit, exp_rdy;
      hit     = cdb_valid && cdb_tag == q && in_rob(q);
      exp_rdy = (in_rob(q) && m_done[q]) || hit;
      check({tag, "_ready"}, rdy, exp_rdy);
      if (exp_rdy) check({tag, "_data"}, dat, hit ? cdb_data : m_data[q]);
   endtask

   // One clock: inputs are already driven; check comb outputs, advance model, check registers.
   task automatic step();
      bit exp_ready;
      #2;
      exp_ready = rob_q.size() < DEPTH && !e_flush;
      check("disp_ready", disp_ready, exp_ready);
      check("disp_tag", disp_tag, next_tag);
      check("wen_rst", Wen_rst, disp_valid && exp_ready && disp_rd_en);
      check("waddr_rst", Waddr_rst, disp_rd_addr);
      check("wdata_rst", Wdata_rst, next_tag);
      check_query("rs", rs_qtag, rs_qready, rs_qdata);
      check_query("rt", rt_qtag, rt_qready, rt_qdata);
      model_step();
      @(posedge clock);
      #1;
      check("rb_valid", RB_valid_rst, e_rb_valid);
      check("rb_tag", RB_tag_rst, e_rb_tag);
      check("commit_wen", commit_wen, e_cwen);
      check("commit_addr", commit_addr, e_caddr);
      check("commit_data", commit_data, e_cdata);
      check("flush", flush, e_flush);
      if (commit_wen) begin
         log_tag.push_back(RB_tag_rst);
         log_data.push_back(commit_data);
      end
      if (flush) flush_log.push_back(RB_tag_rst);
   endtask

   task automatic idle();
      disp_valid = 1'b0; cdb_valid = 1'b0; cdb_mispredict = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic dispatch(logic [4:0] addr);
      cdb_valid = 1'b0; disp_valid = 1'b1; disp_rd_en = 1'b1; disp_rd_addr = addr;
      step();
      disp_valid = 1'b0;
   endtask

   task automatic complete(logic [TAG_W-1:0] t, logic [DATA_W-1:0] d, logic m);
      disp_valid = 1'b0; cdb_valid = 1'b1; cdb_tag = t; cdb_data = d; cdb_mispredict = m;
      step();
      cdb_valid = 1'b0; cdb_mispredict = 1'b0;
   endtask

   task automatic clear_logs();
      log_tag.delete(); log_data.delete(); flush_log.delete();
   endtask

   initial begin
      reset = 1'b1; idle(); disp_rd_en = 1'b0; disp_rd_addr = '0;
      cdb_tag = '0; cdb_data = '0; rs_qtag = '0; rt_qtag = '0;
      rob_q.delete(); next_tag = '0;
      e_rb_tag = '0; e_rb_valid = 1'b0; e_cwen = 1'b0; e_flush = 1'b0; e_caddr = '0; e_cdata = '0;
      for (int i = 0; i < DEPTH; i++) begin
         m_done[i] = 1'b0; m_misp[i] = 1'b0; m_rden[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0;
      end
      @(posedge clock); #1;
      do_reset();

      // Reset state
      check("rst_disp_ready", disp_ready, 1);
      check("rst_disp_tag", disp_tag, 0);
      check("rst_commit_wen", commit_wen, 0);
      check("rst_flush", flush, 0);

      // Fill all 32 entries, then a refused 33rd request
      for (int i = 0; i < DEPTH; i++) begin
         disp_valid = 1'b1; disp_rd_en = 1'b1; disp_rd_addr = 5'(i);
         #1;
         check("fill_tag", disp_tag, i);
         check("fill_wen", Wen_rst, 1);
         check("fill_wdata", Wdata_rst, i);
         step();
      end
      disp_valid = 1'b1; disp_rd_addr = 5'd0;
      #1;
      check("full_ready", disp_ready, 0);
      check("full_wen", Wen_rst, 0);
      step();
      idle();
      check("full_count", dut.count, 32);

      // Same-cycle CDB forward on an operand query
      rs_qtag = 5'd5;
      #1;
      check("fwd_pre_ready", rs_qready, 0);
      cdb_valid = 1'b1; cdb_tag = 5'd5; cdb_data = 32'hABCD;
      #1;
      check("fwd_ready", rs_qready, 1);
      check("fwd_data", rs_qdata, 32'hABCD);
      step();
      idle();

      // Out-of-order completion, in-order retirement
      clear_logs();
      complete(5'd3, 32'd103, 1'b0);
      complete(5'd1, 32'd101, 1'b0);
      complete(5'd0, 32'd100, 1'b0);
      complete(5'd2, 32'd102, 1'b0);
      for (int i = 0; i < 5; i++) step();
      check("order_count", log_tag.size(), 4);
      for (int i = 0; i < 4 && i < log_tag.size(); i++) begin
         check("order_tag", log_tag[i], i);
         check("order_data", log_data[i], 100 + i);
      end

      // Full buffer with head done: commit proceeds, dispatch refused, then wrap to tag 0
      do_reset();
      for (int i = 0; i < DEPTH; i++) dispatch(5'(i));
      complete(5'd0, 32'h55, 1'b0);
      clear_logs();
      disp_valid = 1'b1; disp_rd_addr = 5'd7;
      #1;
      check("fullc_ready", disp_ready, 0);
      step();
      idle();
      check("fullc_commits", log_tag.size(), 1);
      check("fullc_count", dut.count, 31);
      check("fullc_next_ready", disp_ready, 1);
      check("fullc_next_tag", disp_tag, 0);

      // Mispredicted branch at tag 1
      do_reset();
      for (int i = 0; i < 5; i++) dispatch(5'(10 + i));
      clear_logs();
      for (int i = 0; i < 5; i++) complete(5'(i), 32'(200 + i), i == 1);
      for (int i = 0; i < 4; i++) step();
      check("br_commits", log_tag.size(), 2);
      if (log_tag.size() == 2) begin
         check("br_tag0", log_tag[0], 0);
         check("br_tag1", log_tag[1], 1);
      end
      check("br_flushes", flush_log.size(), 1);
      if (flush_log.size() == 1) check("br_flush_tag", flush_log[0], 1);
      check("br_count", dut.count, 0);
      check("br_next_tag", disp_tag, 0);

      // Reset mid-operation with 10 busy entries and a commit ready
      do_reset();
      for (int i = 0; i < 10; i++) dispatch(5'(i));
      complete(5'd0, 32'h77, 1'b1);
      clear_logs();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mrst_rb_valid", RB_valid_rst, 0);
      check("mrst_commit_wen", commit_wen, 0);
      check("mrst_commit_data", commit_data, 0);
      check("mrst_flush", flush, 0);
      check("mrst_ready", disp_ready, 1);
      check("mrst_tag", disp_tag, 0);
      for (int i = 0; i < 3; i++) step();
      check("mrst_no_commit", log_tag.size() + flush_log.size(), 0);

      // Random traffic
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         disp_valid   = ($urandom_range(0, 3) != 0);
         disp_rd_en   = ($urandom_range(0, 4) != 0);
         disp_rd_addr = 5'($urandom);
         cdb_valid    = ($urandom_range(0, 2) != 0);
         if (rob_q.size() != 0 && $urandom_range(0, 4) != 0)
            cdb_tag = rob_q[$urandom_range(0, rob_q.size() - 1)];
         else
            cdb_tag = 5'($urandom);
         cdb_data       = $urandom;
         cdb_mispredict = ($urandom_range(0, 40) == 0);
         rs_qtag = ($urandom_range(0, 1) != 0) ? cdb_tag : 5'($urandom);
         rt_qtag = 5'($urandom);
         step();
      end
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer that allocates the 5-bit tags written into the register status table (`rst`) at dispatch and retires them in program order. At retirement it drives the register-file write and the `RB_tag_rst`/`RB_valid_rst` clear toward `rst`. A mispredicted branch at the head raises `flush` to both `rst` and the front end. It is the producer end of the `rst` write/clear protocol.

## Interface
- `TAG_W`, default 5: tag width; entry count is `DEPTH = 2**TAG_W` (32).
- `DATA_W`, default 32: result width.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `disp_valid`  in  1  dispatch request.
- `disp_rd_en`  in  1  instruction writes a destination register.
- `disp_rd_addr`  in  5  destination register.
- `disp_ready`  out  1  `count < DEPTH` and no flush pending (combinational).
- `disp_tag`  out  TAG_W  tag being allocated, equal to the tail pointer (combinational).
- `Wen_rst`  out  1  `disp_valid & disp_ready & disp_rd_en` (combinational).
- `Waddr_rst`  out  5  equals `disp_rd_addr`.
- `Wdata_rst`  out  5  equals `disp_tag`.
- `cdb_valid`  in  1  result broadcast.
- `cdb_tag`  in  TAG_W  tag of the result.
- `cdb_data`  in  DATA_W  result value.
- `cdb_mispredict`  in  1  entry is a mispredicted branch.
- `rs_qtag`, `rt_qtag`  in  TAG_W  operand tags read from `rst`.
- `rs_qready`, `rt_qready`  out  1  queried entry holds a result (combinational, with CDB forward).
- `rs_qdata`, `rt_qdata`  out  DATA_W  that result.
- `RB_tag_rst`  out  TAG_W  committed tag (registered).
- `RB_valid_rst`  out  1  commit of an entry with `rd_en` (registered).
- `commit_wen`  out  1  register-file write strobe (registered).
- `commit_addr`  out  5  register-file write address (registered).
- `commit_data`  out  DATA_W  register-file write data (registered).
- `flush`  out  1  one-cycle pulse (registered).

## Operation
- Per-entry state: `busy`, `done`, `mispredict`, `rd_en`, `rd_addr[4:0]`, `data`.
- Pointers: `head`, `tail` (TAG_W, wrap modulo DEPTH). Occupancy `count` is 0..DEPTH and is TAG_W+1 bits wide.
- Dispatch is accepted when `disp_valid & disp_ready`:
  - entry[tail] ← busy=1, done=0, rd_en, rd_addr;
  - `tail`++ and `count`++.
- Completion occurs when `cdb_valid` and entry[`cdb_tag`].busy and not done:
  - entry ← done=1, data=`cdb_data`, mispredict=`cdb_mispredict`.
  - A broadcast to a non-busy or already-done entry is ignored.
- Commit happens when `count != 0` and entry[head].done, at most one per cycle:
  - entry[head].busy ← 0; `head`++; `count`--;
  - registered next cycle: `RB_tag_rst`=head, `RB_valid_rst`=`commit_wen`=rd_en, `commit_addr`=rd_addr, `commit_data`=data;
  - if mispredict is set, `flush`=1 on that same next cycle.
- Flush:
  - In the cycle `flush`=1: all busy bits are cleared, `head`=`tail`=0, `count`=0.
  - Dispatch and CDB inputs are ignored in that cycle; `disp_ready`=0.
  - No commit is evaluated in that cycle.
- Query: `qready` = entry[qtag].busy & done, or (`cdb_valid` & `cdb_tag`==qtag & entry busy).
  - `qdata` takes the CDB value on a match, otherwise the entry's data.
- Dispatch, completion and commit in the same cycle are all honoured. The count changes by +1, 0 or −1 accordingly.
- At `count == DEPTH`, dispatch is refused even if a commit occurs that cycle. `disp_ready` is based on the registered count only.

## Timing
- Reset: all registered outputs are 0, `flush`=0, pointers and count are 0, all entries are non-busy.
  - After reset, `disp_ready`=1 and `disp_tag`=0.
  - A reset mid-operation discards all entries without asserting `flush`.
- Dispatch → `Wen_rst`: same cycle, combinational. `rst` captures it at the edge that accepts the dispatch.
- CDB → done: one edge. An entry completed at edge N can commit on the cycle after N, with outputs visible after edge N+1.
- Minimum dispatch-to-commit: the dispatch edge, the CDB edge, then commit outputs one edge later.
- `flush` is high for exactly one cycle. `disp_ready` returns the following cycle with `disp_tag`=0.
- Wrap-around: tag 31 is followed by tag 0; full and empty are distinguished only by `count`.

## Test plan
- Dispatch 32 instructions (rd_addr = i, rd_en=1) after reset:
  - `disp_tag` reads 0..31 and `Wen_rst`/`Waddr_rst`/`Wdata_rst` mirror each dispatch;
  - after the 32nd, `disp_ready`=0 and a 33rd request is ignored.
- Complete tags 3, 1, 0, 2 via CDB (data = 100+tag):
  - commits appear in order 0, 1, 2, 3, one per cycle;
  - `RB_tag_rst` and `commit_addr` follow that order, with `commit_data` 100, 101, 102, 103.
- Query `rs_qtag`=5 with entry 5 pending while the CDB broadcasts tag 5 with data 0xABCD in the same cycle:
  - `rs_qready`=1 and `rs_qdata`=0xABCD combinationally.
- Full buffer, head done, `disp_valid`=1:
  - the commit occurs and the dispatch is refused;
  - the next cycle `disp_ready`=1 and `disp_tag`=0 (wrap).
- Dispatch 5 instructions with tag 1 as a branch, then complete tags 0–4 with tag 1 mispredicted:
  - tags 0 and 1 commit;
  - `flush` pulses once on the cycle tag 1's commit outputs appear;
  - afterwards `count`=0 and the next dispatch gets tag 0.
- Assert `reset` with 10 entries busy:
  - next cycle all outputs are 0, `disp_ready`=1, and no commit or flush is emitted.
